// File: rtl/uart_packetizer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_packetizer                                                            |
// | Buffers camera bytes and frames them as A5 5A SEQ LEN payload CHK packets. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module uart_packetizer #(
  parameter int CHUNK    = 64,
  parameter int DEPTH    = 256,
  parameter int LQ_DEPTH = 4
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        flush,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        overflow,
  input  logic        clr_ovf,
  output logic [15:0] drop_cnt,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam logic [AW:0]   C_DEPTH    = (AW+1)'(DEPTH);
  localparam logic [LW:0]   C_LQ_DEPTH = (LW+1)'(LQ_DEPTH);
  localparam logic [LW-1:0] C_LQ_LAST  = LW'(LQ_DEPTH - 1);
  localparam logic [8:0]    C_CHUNK    = 9'(CHUNK);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SYNC0   = 3'd1,
    S_SYNC1   = 3'd2,
    S_SEQ     = 3'd3,
    S_LEN     = 3'd4,
    S_PAYLOAD = 3'd5,
    S_CHK     = 3'd6
  } state_t;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_fifo_cnt;
  logic [7:0]    r_lq [LQ_DEPTH];
  logic [LW-1:0] r_lq_wr, r_lq_rd;
  logic [LW:0]   r_lq_cnt;
  logic [8:0]    r_open_cnt;
  logic          r_close_pend;
  state_t        r_state;
  logic [7:0]    r_len, r_seq, r_chk;

  logic          w_lq_space, w_pend_exec, w_fifo_full, w_drop, w_wr;
  logic          w_close_req, w_close_now, w_push, w_lq_pop, w_fifo_rd, w_accept;
  logic [8:0]    w_base, w_cnt;
  logic [7:0]    w_push_len, w_head, w_head_next;
  logic [AW-1:0] w_rd_ptr_nx;

  // A pending close runs first, then the byte lands, then a fresh close is evaluated.
  always_comb begin
    w_lq_space  = (r_lq_cnt != C_LQ_DEPTH);
    w_pend_exec = r_close_pend & w_lq_space;
    w_base      = w_pend_exec ? 9'd0 : r_open_cnt;
    w_fifo_full = (r_fifo_cnt == C_DEPTH);
    w_drop      = in_valid & (w_fifo_full | (w_base == C_CHUNK));
    w_wr        = in_valid & ~w_drop;
    w_cnt       = w_base + {8'd0, w_wr};
    w_close_req = (w_cnt == C_CHUNK) | (flush & (w_cnt != 9'd0))
                | (r_close_pend & ~w_pend_exec);
    w_close_now = w_close_req & ~w_pend_exec & w_lq_space;
    w_push      = w_pend_exec | w_close_now;
    w_push_len  = w_pend_exec ? r_open_cnt[7:0] : w_cnt[7:0];
  end

  assign w_accept    = tx_valid & tx_ready;
  assign w_lq_pop    = (r_state == S_IDLE) & (r_lq_cnt != '0);
  assign w_fifo_rd   = (r_state == S_PAYLOAD) & w_accept;
  assign w_rd_ptr_nx = r_rd_ptr + 1'b1;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_next = r_mem[w_rd_ptr_nx];
  assign busy        = (r_state != S_IDLE) | (r_fifo_cnt != '0) | (r_lq_cnt != '0);

  always_ff @(posedge sys_clk) begin
    if (w_wr)   r_mem[r_wr_ptr] <= in_data;
    if (w_push) r_lq[r_lq_wr]   <= w_push_len;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_cnt   <= '0;
      r_lq_wr      <= '0;
      r_lq_rd      <= '0;
      r_lq_cnt     <= '0;
      r_open_cnt   <= '0;
      r_close_pend <= 1'b0;
      overflow     <= 1'b0;
      drop_cnt     <= 16'd0;
    end else begin
      if (w_wr)      r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_fifo_rd) r_rd_ptr <= w_rd_ptr_nx;
      case ({w_wr, w_fifo_rd})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
      if (w_push)   r_lq_wr <= (r_lq_wr == C_LQ_LAST) ? '0 : r_lq_wr + 1'b1;
      if (w_lq_pop) r_lq_rd <= (r_lq_rd == C_LQ_LAST) ? '0 : r_lq_rd + 1'b1;
      case ({w_push, w_lq_pop})
        2'b10:   r_lq_cnt <= r_lq_cnt + 1'b1;
        2'b01:   r_lq_cnt <= r_lq_cnt - 1'b1;
        default: r_lq_cnt <= r_lq_cnt;
      endcase
      r_open_cnt   <= w_close_now ? 9'd0 : w_cnt;
      r_close_pend <= w_close_req & ~w_close_now;
      // A drop in the same cycle as clr_ovf restarts the count at one.
      if (w_drop) begin
        overflow <= 1'b1;
        if (clr_ovf)                 drop_cnt <= 16'd1;
        else if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
        drop_cnt <= 16'd0;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      r_len    <= 8'h00;
      r_seq    <= 8'h00;
      r_chk    <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: if (r_lq_cnt != '0) begin
          r_len    <= r_lq[r_lq_rd];
          r_state  <= S_SYNC0;
          tx_valid <= 1'b1;
          tx_data  <= 8'hA5;
        end
        S_SYNC0: if (w_accept) begin
          r_state <= S_SYNC1;
          tx_data <= 8'h5A;
        end
        S_SYNC1: if (w_accept) begin
          r_state <= S_SEQ;
          tx_data <= r_seq;
        end
        S_SEQ: if (w_accept) begin
          r_chk   <= r_seq;
          r_state <= S_LEN;
          tx_data <= r_len;
        end
        S_LEN: if (w_accept) begin
          r_chk   <= r_chk + r_len;
          r_state <= S_PAYLOAD;
          tx_data <= w_head;
        end
        // The next payload byte is prefetched from the FIFO slot after the head.
        S_PAYLOAD: if (w_accept) begin
          r_chk <= r_chk + tx_data;
          r_len <= r_len - 1'b1;
          if (r_len == 8'd1) begin
            r_state <= S_CHK;
            tx_data <= r_chk + tx_data;
          end else begin
            tx_data <= w_head_next;
          end
        end
        S_CHK: if (w_accept) begin
          r_seq    <= r_seq + 1'b1;
          r_state  <= S_IDLE;
          tx_valid <= 1'b0;
        end
        default: begin
          r_state  <= S_IDLE;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_uart_packetizer.sv
`default_nettype none
// Directed bench for uart_packetizer: reset state, packet framing, flush,
// overflow, backpressure hold, SEQ wrap and mid-packet reset.
module tb_uart_packetizer;
  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        flush = 1'b0;
  logic        clr_ovf = 1'b0;
  logic        rdy_fixed = 1'b0;
  logic        rdy_rand = 1'b0;
  logic        use_rand = 1'b0;
  logic        tx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic        busy;

  assign tx_ready = use_rand ? rdy_rand : rdy_fixed;

  uart_packetizer #(.CHUNK(64), .DEPTH(256), .LQ_DEPTH(4)) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .flush    (flush),
    .tx_ready (tx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .overflow (overflow),
    .clr_ovf  (clr_ovf),
    .drop_cnt (drop_cnt),
    .busy     (busy)
  );

  always #5 sys_clk = ~sys_clk;

  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] pay_q[$];
  logic       hold_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge sys_clk) begin
    if (rst_n && hold_prev) begin
      check("hold_valid", {31'd0, tx_valid}, 32'd1);
      check("hold_data", {24'd0, tx_data}, {24'd0, data_prev});
    end
    hold_prev = rst_n & tx_valid & ~tx_ready;
    data_prev = tx_data;
    if (rst_n && tx_valid && tx_ready) got_q.push_back(tx_data);
  end

  always @(posedge sys_clk) begin
    #1;
    rdy_rand = ($urandom_range(0, 1) == 1);
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic fl);
    in_valid = 1'b1;
    in_data  = b;
    flush    = fl;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    got_q.delete();
  endtask

  task automatic add_pkt(input logic [7:0] seq);
    logic [7:0] chk;
    chk = seq + 8'(pay_q.size());
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(seq);
    exp_q.push_back(8'(pay_q.size()));
    foreach (pay_q[k]) begin
      exp_q.push_back(pay_q[k]);
      chk = chk + pay_q[k];
    end
    exp_q.push_back(chk);
    pay_q.delete();
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      @(negedge sys_clk);
      #1;
      k++;
    end
    check("rx_count_reached", {31'd0, got_q.size() >= n}, 32'd1);
  endtask

  task automatic compare_rx(input string tag);
    wait_rx(exp_q.size(), 4000);
    while (exp_q.size() > 0 && got_q.size() > 0)
      check(tag, {24'd0, got_q.pop_front()}, {24'd0, exp_q.pop_front()});
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d bytes, expected completion", got_q.size());
    $fatal(1);
  end

  initial begin
    logic saw;
    repeat (3) tick();
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'h00);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    rdy_fixed = 1'b1;

    // 64-byte chunk closes on the 64th byte; A5 appears two cycles later
    for (int i = 0; i < 64; i++) send(8'(i), 1'b0);
    check("t1_gap_cycle", {31'd0, tx_valid}, 32'd0);
    tick();
    check("t1_first_valid", {31'd0, tx_valid}, 32'd1);
    check("t1_first_byte", {24'd0, tx_data}, 32'hA5);
    wait_rx(69, 400);
    if (got_q.size() >= 69) begin
      check("t1_len", {24'd0, got_q[3]}, 32'h40);
      check("t1_chk", {24'd0, got_q[68]}, 32'h20);
    end
    for (int i = 0; i < 64; i++) pay_q.push_back(8'(i));
    add_pkt(8'h00);
    compare_rx("t1_stream");
    tick();
    check("t1_busy_after", {31'd0, busy}, 32'd0);
    check("t1_valid_after", {31'd0, tx_valid}, 32'd0);

    send(8'h10, 1'b0);
    send(8'h20, 1'b0);
    send(8'h30, 1'b0);
    flush = 1'b1; tick(); flush = 1'b0;
    exp_q = '{8'hA5, 8'h5A, 8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'h64};
    compare_rx("t2_stream");

    flush = 1'b1; tick(); flush = 1'b0;
    saw = 1'b0;
    repeat (12) begin
      tick();
      if (tx_valid) saw = 1'b1;
    end
    check("t3_no_empty_pkt", {31'd0, saw}, 32'd0);
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
    send(8'h05, 1'b1);
    exp_q = '{8'hA5, 8'h5A, 8'h02, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h16};
    compare_rx("t3_stream");

    // Stalled transmitter: FIFO fills at 256 bytes, the last 44 are dropped
    do_reset();
    rdy_fixed = 1'b0;
    for (int i = 0; i < 300; i++) send(8'(i), 1'b0);
    check("t4_overflow", {31'd0, overflow}, 32'd1);
    check("t4_drop_cnt", {16'd0, drop_cnt}, 32'd44);
    check("t4_busy", {31'd0, busy}, 32'd1);
    check("t4_stall_byte", {24'd0, tx_data}, 32'hA5);
    rdy_fixed = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 64; j++) pay_q.push_back(8'(64 * k + j));
      add_pkt(8'(k));
    end
    compare_rx("t4_stream");
    check("t4_ovf_sticky", {31'd0, overflow}, 32'd1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("t4_clr_overflow", {31'd0, overflow}, 32'd0);
    check("t4_clr_drop_cnt", {16'd0, drop_cnt}, 32'd0);

    use_rand = 1'b1;
    for (int i = 0; i < 100; i++) send(8'(i * 3 + 7), i == 99);
    for (int i = 0; i < 64; i++) pay_q.push_back(8'(i * 3 + 7));
    add_pkt(8'h04);
    for (int i = 64; i < 100; i++) pay_q.push_back(8'(i * 3 + 7));
    add_pkt(8'h05);
    compare_rx("t5_stream");
    use_rand = 1'b0;
    check("t5_no_overflow", {31'd0, overflow}, 32'd0);

    do_reset();
    for (int i = 0; i < 257; i++) begin
      send(8'(i) ^ 8'h3C, 1'b1);
      repeat (8) tick();
      pay_q.push_back(8'(i) ^ 8'h3C);
      add_pkt(8'(i));
    end
    compare_rx("t6_seq_wrap");

    for (int i = 0; i < 10; i++) send(8'h80 + 8'(i), i == 9);
    wait_rx(6, 100);
    #2 rst_n = 1'b0;
    #1;
    check("t7_rst_valid", {31'd0, tx_valid}, 32'd0);
    check("t7_rst_busy", {31'd0, busy}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    got_q.delete();
    saw = 1'b0;
    repeat (10) begin
      tick();
      if (tx_valid) saw = 1'b1;
    end
    check("t7_quiet_after_rst", {31'd0, saw}, 32'd0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b1);
    exp_q = '{8'hA5, 8'h5A, 8'h00, 8'h02, 8'h11, 8'h22, 8'h35};
    compare_rx("t7_stream");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
